// File: rtl/ranc_ctrl_pkg.sv
// ranc_ctrl_pkg: shared state encoding and default parameters for the tick sequencer
package ranc_ctrl_pkg;

    localparam int DEF_PACKET_WIDTH   = 30;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_STEP_WIDTH     = 16;
    localparam int DEF_GUARD_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_TICK,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/ranc_tick_sequencer_if.sv
// ranc_tick_sequencer_if: host, grid and status signals of the tick sequencer
interface ranc_tick_sequencer_if
    import ranc_ctrl_pkg::*;
#(
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int STEP_WIDTH   = DEF_STEP_WIDTH
);
    logic                    start;
    logic [STEP_WIDTH-1:0]   num_steps;
    logic [PACKET_WIDTH-1:0] host_packet;
    logic                    host_valid;
    logic                    host_ready;
    logic                    host_eos;
    logic [PACKET_WIDTH-1:0] grid_packet;
    logic                    grid_empty;
    logic                    grid_ren;
    logic                    grid_tick;
    logic                    grid_cores_done;
    logic                    grid_tc_error;
    logic                    grid_sched_error;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [STEP_WIDTH-1:0]   step_count;

    modport master (
        output start, num_steps, host_packet, host_valid, host_eos,
               grid_ren, grid_cores_done, grid_tc_error, grid_sched_error,
        input  host_ready, grid_packet, grid_empty, grid_tick,
               busy, done, error, step_count
    );

    modport slave (
        input  start, num_steps, host_packet, host_valid, host_eos,
               grid_ren, grid_cores_done, grid_tc_error, grid_sched_error,
        output host_ready, grid_packet, grid_empty, grid_tick,
               busy, done, error, step_count
    );

endinterface

// File: rtl/ranc_packet_fifo.sv
// ranc_packet_fifo: first-word fall-through staging FIFO between host and grid
module ranc_packet_fifo
    import ranc_ctrl_pkg::*;
#(
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push_i,
    input  logic [PACKET_WIDTH-1:0] data_i,
    input  logic                    pop_i,
    output logic [PACKET_WIDTH-1:0] data_o,
    output logic                    empty_o,
    output logic                    full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_q, rd_q;
    logic [AW:0]             count_q;
    logic                    wr, rd;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(FIFO_DEPTH);
    assign rd      = pop_i && !empty_o;
    assign wr      = push_i && (!full_o || rd);
    assign data_o  = mem_q[rd_q];

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr) wr_q <= wr_q + AW'(1);
            if (rd) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    // packet storage needs no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ranc_tick_sequencer.sv
// ranc_tick_sequencer: stages host packets per timestep, then ticks the grid and waits for completion
module ranc_tick_sequencer
    import ranc_ctrl_pkg::*;
#(
    parameter int PACKET_WIDTH   = DEF_PACKET_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int STEP_WIDTH     = DEF_STEP_WIDTH,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                  clk,
    input logic                  reset_n,
    ranc_tick_sequencer_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state_q, state_d;
    logic [STEP_WIDTH-1:0]   num_q, step_q;
    logic [WAIT_W-1:0]       wait_q;
    logic                    tick_q, busy_q, done_q, error_q;
    logic                    fifo_empty, fifo_full, push;
    logic                    launch, grid_err, accept, timeout, last_step;
    logic [PACKET_WIDTH-1:0] head;

    assign grid_err  = bus.grid_tc_error || bus.grid_sched_error;
    assign launch    = bus.start && (state_q == S_IDLE || (state_q == S_DONE && !grid_err));
    assign accept    = bus.grid_cores_done && wait_q >= WAIT_W'(GUARD_CYCLES);
    assign timeout   = wait_q >= WAIT_W'(TIMEOUT_CYCLES - 1);
    assign last_step = {1'b0, step_q} + (STEP_WIDTH+1)'(1) == {1'b0, num_q};
    assign push      = bus.host_ready && bus.host_valid;

    assign bus.host_ready  = state_q == S_LOAD && !fifo_full;
    assign bus.grid_packet = head;
    assign bus.grid_empty  = fifo_empty;
    assign bus.grid_tick   = tick_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.step_count  = step_q;

    ranc_packet_fifo #(
        .PACKET_WIDTH(PACKET_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push_i (push),
        .data_i (bus.host_packet),
        .pop_i  (bus.grid_ren),
        .data_o (head),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    // next state; grid errors override every other transition outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = launch ? (bus.num_steps == '0 ? S_DONE : S_LOAD) : state_q;
            S_LOAD:         state_d = bus.host_eos ? S_DRAIN : S_LOAD;
            S_DRAIN:        state_d = fifo_empty ? S_TICK : S_DRAIN;
            S_TICK:         state_d = S_WAIT_DONE;
            S_WAIT_DONE:    state_d = accept ? (last_step ? S_DONE : S_LOAD) : (timeout ? S_ERROR : S_WAIT_DONE);
            default:        state_d = S_ERROR;
        endcase
        if (state_q != S_IDLE && grid_err) state_d = S_ERROR;
    end

    // state, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            step_q  <= '0;
            wait_q  <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= state_d == S_TICK;
            busy_q  <= state_d inside {S_LOAD, S_DRAIN, S_TICK, S_WAIT_DONE};
            done_q  <= state_d == S_DONE;
            error_q <= state_d == S_ERROR;
            wait_q  <= state_q == S_WAIT_DONE ? wait_q + WAIT_W'(1) : '0;
            if (launch) begin
                num_q  <= bus.num_steps;
                step_q <= '0;
            end else if (state_q == S_WAIT_DONE && accept && !grid_err) begin
                step_q <= &step_q ? step_q : step_q + STEP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ranc_tick_sequencer.sv
// tb_ranc_tick_sequencer: table vectors, directed corner sequences and a queue-based random model
module tb_ranc_tick_sequencer;
    localparam int PW    = 30;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int GUARD = 2;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ranc_tick_sequencer_if #(.PACKET_WIDTH(PW), .STEP_WIDTH(SW)) bus();

    ranc_tick_sequencer #(
        .PACKET_WIDTH  (PW),
        .FIFO_DEPTH    (DEPTH),
        .STEP_WIDTH    (SW),
        .GUARD_CYCLES  (GUARD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [PW-1:0] pkt;
        logic          ren;
        logic          exp_hr;
        logic          exp_empty;
        logic [PW-1:0] exp_head;
    } vec_t;

    vec_t tbl[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start            = 1'b0;
        bus.num_steps        = '0;
        bus.host_packet      = '0;
        bus.host_valid       = 1'b0;
        bus.host_eos         = 1'b0;
        bus.grid_ren         = 1'b0;
        bus.grid_cores_done  = 1'b0;
        bus.grid_tc_error    = 1'b0;
        bus.grid_sched_error = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_empty"}, bus.grid_empty, 1);
        check({tag, "_tick"}, bus.grid_tick, 0);
        check({tag, "_ready"}, bus.host_ready, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
        check({tag, "_steps"}, bus.step_count, 0);
    endtask

    task automatic launch(input int num);
        bus.num_steps = SW'(num);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic count_ticks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            n += int'(bus.grid_tick);
        end
    endtask

    // reference: FIFO contents as a queue, step acceptance at max(done asserted, tick+GUARD+1)
    task automatic run_model(input int num, input bit rnd);
        logic [PW-1:0] q[$];
        logic [PW-1:0] pkt;
        int  exp_step = 0;
        int  ticks = 0;
        int  cyc = 0;
        int  cd_at = -1;
        int  acc_at = -1;
        int  pkts_left;
        bit  eos_sent = 1'b0;
        bit  pushed;
        launch(num);
        pkts_left = rnd ? int'($urandom_range(0, 6)) : 2;
        while (exp_step < num && cyc < 3000) begin
            check("model_empty", bus.grid_empty, q.size() == 0);
            if (q.size() != 0) check("model_head", bus.grid_packet, q[0]);
            check("model_steps", bus.step_count, exp_step);
            check("model_ready_full", bus.host_ready && q.size() >= DEPTH, 0);
            check("model_bad_tick", bus.grid_tick && (!eos_sent || q.size() != 0), 0);
            if (bus.grid_tick) begin
                ticks++;
                eos_sent = 1'b0;
                cd_at  = cyc + (rnd ? int'($urandom_range(1, 7)) : 5);
                acc_at = cd_at > cyc + GUARD + 1 ? cd_at : cyc + GUARD + 1;
            end
            bus.grid_cores_done = acc_at >= 0 && cyc >= cd_at;
            bus.grid_ren   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.host_valid = 1'b0;
            bus.host_eos   = 1'b0;
            pushed = 1'b0;
            pkt = PW'($urandom);
            bus.host_packet = pkt;
            if (bus.host_ready && !eos_sent) begin
                if (pkts_left > 0) begin
                    bus.host_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (bus.host_valid) begin
                        pushed = 1'b1;
                        pkts_left--;
                        if (pkts_left == 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                            bus.host_eos = 1'b1;
                            eos_sent = 1'b1;
                        end
                    end
                end else begin
                    bus.host_eos = 1'b1;
                    eos_sent = 1'b1;
                end
            end
            if (bus.grid_ren && q.size() != 0) void'(q.pop_front());
            if (pushed) q.push_back(pkt);
            if (acc_at >= 0 && cyc == acc_at) begin
                exp_step++;
                acc_at = -1;
                pkts_left = rnd ? int'($urandom_range(0, 6)) : 2;
            end
            step();
            cyc++;
        end
        idle_inputs();
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL model_budget: run of %0d steps did not complete in %0d cycles", num, cyc);
        end
        check("model_final_steps", bus.step_count, num);
        check("model_final_done", bus.done, 1);
        check("model_final_busy", bus.busy, 0);
        check("model_ticks", ticks, num);
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 30'h0A0A_0001, 1'b0, 1'b1, 1'b1, 30'h0};
        tbl[1]  = '{1'b1, 30'h0B0B_0002, 1'b0, 1'b1, 1'b0, 30'h0A0A_0001};
        tbl[2]  = '{1'b1, 30'h0C0C_0003, 1'b0, 1'b1, 1'b0, 30'h0A0A_0001};
        tbl[3]  = '{1'b1, 30'h0D0D_0004, 1'b0, 1'b1, 1'b0, 30'h0A0A_0001};
        tbl[4]  = '{1'b1, 30'h0E0E_0005, 1'b0, 1'b0, 1'b0, 30'h0A0A_0001};
        tbl[5]  = '{1'b1, 30'h0E0E_0005, 1'b1, 1'b0, 1'b0, 30'h0A0A_0001};
        tbl[6]  = '{1'b1, 30'h0E0E_0005, 1'b1, 1'b1, 1'b0, 30'h0B0B_0002};
        tbl[7]  = '{1'b0, 30'h0,         1'b1, 1'b1, 1'b0, 30'h0C0C_0003};
        tbl[8]  = '{1'b0, 30'h0,         1'b1, 1'b1, 1'b0, 30'h0D0D_0004};
        tbl[9]  = '{1'b0, 30'h0,         1'b1, 1'b1, 1'b0, 30'h0E0E_0005};
        tbl[10] = '{1'b0, 30'h0,         1'b0, 1'b1, 1'b1, 30'h0};

        do_reset();
        check_reset_outs("rst");

        // fill to full with reads held off, then drain A..E in order
        launch(1);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("fifo_ready[%0d]", i), bus.host_ready, tbl[i].exp_hr);
            check($sformatf("fifo_empty[%0d]", i), bus.grid_empty, tbl[i].exp_empty);
            if (!tbl[i].exp_empty) check($sformatf("fifo_head[%0d]", i), bus.grid_packet, tbl[i].exp_head);
            bus.host_valid  = tbl[i].valid;
            bus.host_packet = tbl[i].pkt;
            bus.grid_ren    = tbl[i].ren;
            step();
        end
        idle_inputs();

        // empty step: tick two cycles after eos; done held high is accepted GUARD+1 after the tick
        bus.host_eos = 1'b1;
        step();
        bus.host_eos = 1'b0;
        check("empty_step_tick_early", bus.grid_tick, 0);
        check("empty_step_empty1", bus.grid_empty, 1);
        step();
        check("empty_step_tick", bus.grid_tick, 1);
        check("empty_step_empty2", bus.grid_empty, 1);
        bus.grid_cores_done = 1'b1;
        step();
        check("tick_one_cycle", bus.grid_tick, 0);
        step();
        step();
        check("guard_steps_before", bus.step_count, 0);
        check("guard_done_before", bus.done, 0);
        step();
        check("guard_steps_after", bus.step_count, 1);
        check("guard_done_after", bus.done, 1);
        check("guard_busy_after", bus.busy, 0);
        bus.grid_cores_done = 1'b0;

        // timeout: start from DONE, never answer the tick
        launch(2);
        check("restart_busy", bus.busy, 1);
        check("restart_done", bus.done, 0);
        bus.host_eos = 1'b1;
        step();
        bus.host_eos = 1'b0;
        step();
        check("tmo_tick", bus.grid_tick, 1);
        for (int i = 0; i < TMO; i++) step();
        check("tmo_still_busy", bus.busy, 1);
        check("tmo_no_error_yet", bus.error, 0);
        step();
        check("tmo_error", bus.error, 1);
        check("tmo_busy", bus.busy, 0);
        check("tmo_ready", bus.host_ready, 0);
        bus.start = 1'b1;
        bus.num_steps = 16'd1;
        count_ticks(20, n);
        bus.start = 1'b0;
        check("tmo_no_ticks", n, 0);
        check("tmo_error_sticky", bus.error, 1);
        check("tmo_no_done", bus.done, 0);
        do_reset();
        check_reset_outs("rst_after_tmo");

        // scheduler error in LOAD; FIFO stays drainable in ERROR
        launch(2);
        bus.host_valid = 1'b1;
        bus.host_packet = 30'h1234_5678;
        step();
        bus.host_valid = 1'b0;
        check("serr_loaded", bus.grid_empty, 0);
        bus.grid_sched_error = 1'b1;
        step();
        bus.grid_sched_error = 1'b0;
        check("serr_error", bus.error, 1);
        check("serr_busy", bus.busy, 0);
        check("serr_ready", bus.host_ready, 0);
        check("serr_head", bus.grid_packet, 30'h1234_5678);
        bus.grid_ren = 1'b1;
        step();
        bus.grid_ren = 1'b0;
        check("serr_drained", bus.grid_empty, 1);
        do_reset();

        // eos while full: extra packet dropped, four drain then tick
        launch(1);
        for (int i = 0; i < DEPTH; i++) begin
            bus.host_valid = 1'b1;
            bus.host_packet = PW'(32'h100 + i);
            step();
        end
        check("full_ready", bus.host_ready, 0);
        bus.host_packet = 30'h3FF;
        bus.host_eos = 1'b1;
        step();
        bus.host_valid = 1'b0;
        bus.host_eos = 1'b0;
        check("full_eos_busy", bus.busy, 1);
        bus.grid_ren = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("full_drain_head[%0d]", i), bus.grid_packet, PW'(32'h100 + i));
            step();
        end
        check("full_drain_empty", bus.grid_empty, 1);
        check("full_drain_no_tick", bus.grid_tick, 0);
        step();
        check("full_drain_tick", bus.grid_tick, 1);
        do_reset();

        // reset during DRAIN flushes the FIFO
        launch(1);
        for (int i = 0; i < 2; i++) begin
            bus.host_valid = 1'b1;
            bus.host_packet = PW'(32'h200 + i);
            step();
        end
        bus.host_valid = 1'b0;
        bus.host_eos = 1'b1;
        step();
        bus.host_eos = 1'b0;
        check("drain_pending", bus.grid_empty, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_reset_outs("rst_drain");
        count_ticks(10, n);
        check("rst_drain_no_tick", n, 0);
        check("rst_drain_still_empty", bus.grid_empty, 1);

        // reset during TICK
        launch(1);
        bus.host_eos = 1'b1;
        step();
        bus.host_eos = 1'b0;
        step();
        check("rst_tick_pre", bus.grid_tick, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_reset_outs("rst_tick");
        count_ticks(8, n);
        check("rst_tick_no_tick", n, 0);

        // zero steps goes straight to DONE
        launch(0);
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
        check("zero_steps", bus.step_count, 0);

        // three steps of two packets, done five cycles after each tick, then random runs
        run_model(3, 1'b0);
        run_model(4, 1'b1);
        run_model(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ranc_tick_sequencer.md
RANC_TICK_SEQUENCER -- requirements
Module: ranc_tick_sequencer

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 30, meaning the width of a grid input packet.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), meaning the staging FIFO entry count.
REQ-003 SHALL have parameter STEP_WIDTH, default 16, meaning the width of the timestep counter and num_steps.
REQ-004 SHALL have parameter GUARD_CYCLES, default 2, meaning the cycles after grid_tick during which grid_cores_done is ignored.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum wait for grid_cores_done before error.
REQ-006 SHALL have ports: clk in 1, the single clock; reset_n in 1, reset that is synchronous and active-low.
REQ-007 SHALL have ports: start in 1, run request; num_steps in STEP_WIDTH, timesteps to run, sampled on accepted start.
REQ-008 SHALL have ports: host_packet in PACKET_WIDTH; host_valid in 1; host_ready out 1, so that a packet transfers when valid&ready.
REQ-009 SHALL have ports: host_eos in 1, end-of-step marker for the current step, which may coincide with a packet transfer.
REQ-010 SHALL have ports: grid_packet out PACKET_WIDTH, FIFO head; grid_empty out 1; grid_ren in 1, grid read strobe.
REQ-011 SHALL have ports: grid_tick out 1, one-cycle tick pulse; grid_cores_done in 1; grid_tc_error in 1; grid_sched_error in 1.
REQ-012 SHALL have ports: busy out 1; done out 1, sticky; error out 1, sticky; step_count out STEP_WIDTH, completed steps.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD, DRAIN, TICK, WAIT_DONE, DONE and ERROR.
REQ-014 In IDLE, start=1 SHALL latch num_steps, clear step_count/done and go to LOAD, or to DONE if num_steps=0.
REQ-015 start SHALL be ignored in every state except IDLE and DONE; start in DONE SHALL behave as in IDLE.
REQ-016 host_ready SHALL be 1 only in LOAD with the FIFO not full, and a push SHALL occur on host_valid&host_ready.
REQ-017 In LOAD, host_eos=1 SHALL move the FSM to DRAIN, with any packet pushed in the same cycle included in the step.
REQ-018 host_eos with no packets (an empty step) SHALL be legal.
REQ-019 In LOAD when the FIFO is full, host_eos SHALL still be honoured, while host_packet SHALL NOT be pushed.
REQ-020 grid_packet SHALL be the FIFO head (first-word fall-through), grid_empty SHALL equal FIFO empty, and a pop SHALL occur on grid_ren&!grid_empty.
REQ-021 grid_ren while empty SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL be permitted in any fill state, leaving the count unchanged.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-024 DRAIN SHALL go to TICK in the first cycle the FIFO is empty.
REQ-025 TICK SHALL last exactly 1 cycle with grid_tick=1, then go to WAIT_DONE; grid_tick SHALL be 0 in all other states.
REQ-026 WAIT_DONE SHALL ignore grid_cores_done for GUARD_CYCLES cycles, then accept grid_cores_done=1.
REQ-027 On acceptance in WAIT_DONE, step_count SHALL increment by 1, and the FSM SHALL go to DONE if step_count+1 equals the latched num_steps, else to LOAD.
REQ-028 WAIT_DONE SHALL count cycles, and reaching TIMEOUT_CYCLES SHALL move the FSM to ERROR.
REQ-029 grid_tc_error|grid_sched_error in any non-IDLE state SHALL move the FSM to ERROR, with priority over all other transitions.
REQ-030 ERROR SHALL be exited only by reset; in ERROR, error=1, host_ready=0, grid_tick=0, and the FIFO SHALL still be drainable by the grid.
REQ-031 busy SHALL be 1 in LOAD, DRAIN, TICK and WAIT_DONE; done SHALL be 1 in DONE.
REQ-032 Latency from FIFO empty in DRAIN to grid_tick SHALL be 1 cycle.
REQ-033 step_count SHALL saturate rather than wrap; with num_steps of all ones, it stops at the maximum and then DONE.

Reset
REQ-034 When reset_n=0 at a clk edge, the FSM SHALL go to IDLE, the FIFO SHALL be flushed, and the counters SHALL clear.
REQ-035 Outputs during reset SHALL be: grid_empty=1, grid_tick=0, host_ready=0, busy/done/error=0, step_count=0; grid_packet SHALL be don't-care.
REQ-036 Reset mid-operation, including during TICK, SHALL abort with no further grid_tick pulse.

Structure
REQ-037 The state encoding and the default parameter values SHALL reside in a shared package, ranc_ctrl_pkg.
REQ-038 The staging FIFO SHALL be a sub-module, ranc_packet_fifo, parameterised by PACKET_WIDTH and FIFO_DEPTH.

Verification
REQ-039 The bench SHALL cover: num_steps=3, 2 packets+eos per step, cores_done 5 cycles after each tick -> 3 grid_tick pulses, step_count=3, done=1.
REQ-040 The bench SHALL cover: push 5 packets with DEPTH=4 and grid_ren=0 -> host_ready=0 after the 4th; release grid_ren -> packets exit in order A..E.
REQ-041 The bench SHALL cover: eos with no packets -> grid_tick exactly 2 cycles after eos, with grid_empty staying 1.
REQ-042 The bench SHALL cover: grid_cores_done held 1 throughout -> acceptance exactly GUARD_CYCLES+1 cycles after the tick.
REQ-043 The bench SHALL cover: grid_cores_done never asserted, TIMEOUT_CYCLES=16 -> error=1, busy=0, no further ticks.
REQ-044 The bench SHALL cover: grid_sched_error=1 in LOAD, and reset_n=0 during DRAIN -> ERROR then IDLE, the FIFO empty, and all outputs at their reset values.
